// File: rtl/i2c_txn_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_txn_scheduler_if
//  Description : Bundles the write/read request ports, the write/read
//                response ports and the I2C master command/completion
//                signals seen by the transaction scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_txn_scheduler_if;
  // Write request from the AXI slave front end
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] wr_slv;

  // Read request from the AXI slave front end
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_addr;
  logic [6:0] rd_slv;

  // Write response back to the AXI slave front end
  logic       bresp_valid;
  logic       bresp_ready;
  logic       bresp_err;

  // Read response back to the AXI slave front end
  logic       rresp_valid;
  logic       rresp_ready;
  logic [7:0] rresp_data;
  logic       rresp_err;

  // Command handoff to the I2C master
  logic [7:0] m_addr;
  logic [7:0] m_din;
  logic [6:0] m_slv_addr;
  logic       m_op_type;
  logic       m_cmd_valid;
  logic       m_cmd_ack;
  logic       m_trigger;

  // Completion and read data from the I2C master
  logic       m_wr_done;
  logic       m_nack;
  logic [7:0] m_rdata;
  logic       m_rdata_valid;
  logic       m_rdata_ack;

  // Status
  logic       pending_wr;
  logic       pending_rd;
  logic       busy;

  // Scheduler side
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_slv,
    input  rd_valid, rd_addr, rd_slv,
    input  bresp_ready, rresp_ready,
    input  m_cmd_ack, m_wr_done, m_nack, m_rdata, m_rdata_valid,
    output wr_ready, rd_ready,
    output bresp_valid, bresp_err,
    output rresp_valid, rresp_data, rresp_err,
    output m_addr, m_din, m_slv_addr, m_op_type, m_cmd_valid, m_trigger,
    output m_rdata_ack,
    output pending_wr, pending_rd, busy
  );

  // Environment side (AXI front end plus I2C master)
  modport master (
    output wr_valid, wr_addr, wr_data, wr_slv,
    output rd_valid, rd_addr, rd_slv,
    output bresp_ready, rresp_ready,
    output m_cmd_ack, m_wr_done, m_nack, m_rdata, m_rdata_valid,
    input  wr_ready, rd_ready,
    input  bresp_valid, bresp_err,
    input  rresp_valid, rresp_data, rresp_err,
    input  m_addr, m_din, m_slv_addr, m_op_type, m_cmd_valid, m_trigger,
    input  m_rdata_ack,
    input  pending_wr, pending_rd, busy
  );
endinterface
`default_nettype wire

// File: rtl/i2c_txn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_txn_scheduler
//  Description : Round-robin arbiter and sequencer that issues one AXI-side
//                register write or read at a time to the shared I2C master,
//                guarded by a watchdog, and returns the response.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_txn_scheduler #(
  parameter int  TIMEOUT_CYCLES = 4096,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input wire                 clk,
  input wire                 reset,
  i2c_txn_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    TRIG  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  // Timeout fires when the count observed this cycle is the last allowed one,
  // so the abort lands exactly TIMEOUT_CYCLES cycles after leaving IDLE.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] wd_cnt;

  logic [7:0]       cmd_addr;
  logic [7:0]       cmd_din;
  logic [6:0]       cmd_slv;
  logic             cmd_op;
  logic             cmd_valid;
  logic             trigger;

  logic             bresp_valid;
  logic             bresp_err;
  logic             rresp_valid;
  logic [7:0]       rresp_data;
  logic             rresp_err;
  logic             pending_wr;
  logic             pending_rd;

  logic             grant_wr;
  logic             grant_rd;
  logic             timeout;
  logic             wr_done;
  logic             rd_done;

  // Grant only in IDLE and out of reset; on contention alternate away from last winner
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE && !reset) begin
      if (bus.wr_valid && (!bus.rd_valid || last_grant == GRANT_RD)) begin
        grant_wr = 1'b1;
      end else if (bus.rd_valid) begin
        grant_rd = 1'b1;
      end
    end
  end

  assign timeout = (wd_cnt >= CNT_LIMIT);
  assign wr_done = (state == WAIT) && (cmd_op == GRANT_WR) && bus.m_wr_done;
  assign rd_done = (state == WAIT) && (cmd_op == GRANT_RD) && bus.m_rdata_valid;

  // Transaction sequencer: arbitration, command handoff, completion, watchdog, response
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GRANT_RD;
      wd_cnt      <= '0;
      cmd_addr    <= 8'h00;
      cmd_din     <= 8'h00;
      cmd_slv     <= 7'h00;
      cmd_op      <= 1'b0;
      cmd_valid   <= 1'b0;
      trigger     <= 1'b0;
      bresp_valid <= 1'b0;
      bresp_err   <= 1'b0;
      rresp_valid <= 1'b0;
      rresp_data  <= 8'h00;
      rresp_err   <= 1'b0;
      pending_wr  <= 1'b0;
      pending_rd  <= 1'b0;
    end else begin
      if ((state == ISSUE || state == TRIG || state == WAIT) && wd_cnt != CNT_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_wr) begin
            cmd_addr   <= bus.wr_addr;
            cmd_din    <= bus.wr_data;
            cmd_slv    <= bus.wr_slv;
            cmd_op     <= GRANT_WR;
            last_grant <= GRANT_WR;
            pending_wr <= 1'b1;
            cmd_valid  <= 1'b1;
            wd_cnt     <= '0;
            state      <= ISSUE;
          end else if (grant_rd) begin
            cmd_addr   <= bus.rd_addr;
            cmd_din    <= 8'h00;
            cmd_slv    <= bus.rd_slv;
            cmd_op     <= GRANT_RD;
            last_grant <= GRANT_RD;
            pending_rd <= 1'b1;
            cmd_valid  <= 1'b1;
            wd_cnt     <= '0;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          // An ack means the master owns the command, so it always gets its trigger
          if (bus.m_cmd_ack) begin
            cmd_valid <= 1'b0;
            trigger   <= 1'b1;
            state     <= TRIG;
          end else if (timeout) begin
            cmd_valid <= 1'b0;
            if (cmd_op == GRANT_RD) begin
              rresp_valid <= 1'b1;
              rresp_data  <= 8'h00;
              rresp_err   <= 1'b1;
            end else begin
              bresp_valid <= 1'b1;
              bresp_err   <= 1'b1;
            end
            state <= RESP;
          end
        end

        TRIG: begin
          trigger <= 1'b0;
          state   <= WAIT;
        end

        WAIT: begin
          // Completion takes priority over a timeout in the same cycle
          if (wr_done) begin
            bresp_valid <= 1'b1;
            bresp_err   <= bus.m_nack;
            state       <= RESP;
          end else if (rd_done) begin
            rresp_valid <= 1'b1;
            rresp_data  <= bus.m_rdata;
            rresp_err   <= bus.m_nack;
            state       <= RESP;
          end else if (timeout) begin
            if (cmd_op == GRANT_RD) begin
              rresp_valid <= 1'b1;
              rresp_data  <= 8'h00;
              rresp_err   <= 1'b1;
            end else begin
              bresp_valid <= 1'b1;
              bresp_err   <= 1'b1;
            end
            state <= RESP;
          end
        end

        RESP: begin
          if (bresp_valid && bus.bresp_ready) begin
            bresp_valid <= 1'b0;
            pending_wr  <= 1'b0;
            state       <= IDLE;
          end else if (rresp_valid && bus.rresp_ready) begin
            rresp_valid <= 1'b0;
            pending_rd  <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_ready    = grant_wr;
  assign bus.rd_ready    = grant_rd;
  assign bus.bresp_valid = bresp_valid;
  assign bus.bresp_err   = bresp_err;
  assign bus.rresp_valid = rresp_valid;
  assign bus.rresp_data  = rresp_data;
  assign bus.rresp_err   = rresp_err;
  assign bus.m_addr      = cmd_addr;
  assign bus.m_din       = cmd_din;
  assign bus.m_slv_addr  = cmd_slv;
  assign bus.m_op_type   = cmd_op;
  assign bus.m_cmd_valid = cmd_valid;
  assign bus.m_trigger   = trigger;
  // Read data is acknowledged in the very cycle it is captured
  assign bus.m_rdata_ack = rd_done;
  assign bus.pending_wr  = pending_wr;
  assign bus.pending_rd  = pending_rd;
  assign bus.busy        = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_txn_scheduler
//  Description : Directed self-checking bench for i2c_txn_scheduler with a
//                16-cycle watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_scheduler;

  localparam int TIMEOUT_CYCLES = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  i2c_txn_scheduler_if bus ();

  i2c_txn_scheduler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every DUT output packed together; all-zero is the reset state
  function automatic logic [43:0] outs_vec();
    return {bus.wr_ready, bus.rd_ready, bus.bresp_valid, bus.bresp_err,
            bus.rresp_valid, bus.rresp_data, bus.rresp_err, bus.m_addr,
            bus.m_din, bus.m_slv_addr, bus.m_op_type, bus.m_cmd_valid,
            bus.m_trigger, bus.m_rdata_ack, bus.pending_wr, bus.pending_rd,
            bus.busy};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs_vec() !== 44'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", outs_vec());
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_vec() !== 44'h0) begin
      errors++;
      $display("FAIL reset_release_idle: got %h want 0", outs_vec());
    end
  endtask

  task automatic test_single_write();
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h10; bus.wr_data = 8'hA5; bus.wr_slv = 7'h50;
    #1;
    checks++;
    if ({bus.wr_ready, bus.rd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL wr_grant: got %b want 10", {bus.wr_ready, bus.rd_ready});
    end
    @(negedge clk); bus.wr_valid = 1'b0;             // ISSUE, cycle 1
    checks++;
    if ({bus.m_cmd_valid, bus.m_op_type, bus.m_addr, bus.m_din, bus.m_slv_addr} !== {1'b1, 1'b0, 8'h10, 8'hA5, 7'h50}) begin
      errors++;
      $display("FAIL wr_cmd: got %h want %h", {bus.m_cmd_valid, bus.m_op_type, bus.m_addr, bus.m_din, bus.m_slv_addr},
               {1'b1, 1'b0, 8'h10, 8'hA5, 7'h50});
    end
    checks++;
    if ({bus.pending_wr, bus.pending_rd, bus.busy, bus.wr_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL wr_status: got %b want 1010", {bus.pending_wr, bus.pending_rd, bus.busy, bus.wr_ready});
    end
    @(negedge clk);                                  // cycle 2, no ack yet
    checks++;
    if ({bus.m_cmd_valid, bus.m_trigger} !== 2'b10) begin
      errors++;
      $display("FAIL wr_issue_hold: got %b want 10", {bus.m_cmd_valid, bus.m_trigger});
    end
    bus.m_cmd_ack = 1'b1;
    @(negedge clk); bus.m_cmd_ack = 1'b0;            // TRIG
    checks++;
    if ({bus.m_trigger, bus.m_cmd_valid} !== 2'b10) begin
      errors++;
      $display("FAIL wr_trigger: got %b want 10", {bus.m_trigger, bus.m_cmd_valid});
    end
    @(negedge clk);                                  // WAIT
    checks++;
    if ({bus.m_trigger, bus.m_cmd_valid, bus.m_addr} !== {1'b0, 1'b0, 8'h10}) begin
      errors++;
      $display("FAIL wr_trigger_once: got %h want 010", {bus.m_trigger, bus.m_cmd_valid, bus.m_addr});
    end
    bus.m_rdata_valid = 1'b1; #1;
    checks++;
    if (bus.m_rdata_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_rdata_ignored: got %b want 0", bus.m_rdata_ack);
    end
    @(negedge clk); bus.m_rdata_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.m_wr_done = 1'b1; bus.m_nack = 1'b0;
    @(negedge clk); bus.m_wr_done = 1'b0;            // RESP
    checks++;
    if ({bus.bresp_valid, bus.bresp_err, bus.rresp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL wr_bresp: got %b want 100", {bus.bresp_valid, bus.bresp_err, bus.rresp_valid});
    end
    @(negedge clk);
    checks++;
    if ({bus.bresp_valid, bus.bresp_err, bus.pending_wr, bus.busy} !== 4'b1011) begin
      errors++;
      $display("FAIL wr_bresp_hold: got %b want 1011", {bus.bresp_valid, bus.bresp_err, bus.pending_wr, bus.busy});
    end
    bus.bresp_ready = 1'b1;
    @(negedge clk); bus.bresp_ready = 1'b0;
    checks++;
    if ({bus.bresp_valid, bus.pending_wr, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL wr_back_to_idle: got %b want 000", {bus.bresp_valid, bus.pending_wr, bus.busy});
    end
  endtask

  task automatic test_single_read();
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h22; bus.rd_slv = 7'h50;
    #1;
    checks++;
    if ({bus.wr_ready, bus.rd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rd_grant: got %b want 01", {bus.wr_ready, bus.rd_ready});
    end
    @(negedge clk); bus.rd_valid = 1'b0;
    checks++;
    if ({bus.m_cmd_valid, bus.m_op_type, bus.m_addr, bus.m_slv_addr, bus.pending_wr, bus.pending_rd, bus.busy}
        !== {1'b1, 1'b1, 8'h22, 7'h50, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rd_cmd: got %h want %h", {bus.m_cmd_valid, bus.m_op_type, bus.m_addr, bus.m_slv_addr, bus.pending_wr, bus.pending_rd, bus.busy},
               {1'b1, 1'b1, 8'h22, 7'h50, 1'b0, 1'b1, 1'b1});
    end
    bus.m_cmd_ack = 1'b1;
    @(negedge clk); bus.m_cmd_ack = 1'b0;
    checks++;
    if (bus.m_trigger !== 1'b1) begin
      errors++;
      $display("FAIL rd_trigger: got %b want 1", bus.m_trigger);
    end
    @(negedge clk);                                  // WAIT
    bus.m_wr_done = 1'b1;
    @(negedge clk); bus.m_wr_done = 1'b0;
    checks++;
    if ({bus.rresp_valid, bus.bresp_valid, bus.busy} !== 3'b001) begin
      errors++;
      $display("FAIL rd_wrdone_ignored: got %b want 001", {bus.rresp_valid, bus.bresp_valid, bus.busy});
    end
    bus.m_rdata = 8'h3C; bus.m_rdata_valid = 1'b1; bus.m_nack = 1'b0; #1;
    checks++;
    if (bus.m_rdata_ack !== 1'b1) begin
      errors++;
      $display("FAIL rd_rdata_ack: got %b want 1", bus.m_rdata_ack);
    end
    @(negedge clk); bus.m_rdata_valid = 1'b0;
    checks++;
    if ({bus.m_rdata_ack, bus.rresp_valid, bus.rresp_data, bus.rresp_err, bus.bresp_valid} !== {1'b0, 1'b1, 8'h3C, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rd_rresp: got %h want %h", {bus.m_rdata_ack, bus.rresp_valid, bus.rresp_data, bus.rresp_err, bus.bresp_valid},
               {1'b0, 1'b1, 8'h3C, 1'b0, 1'b0});
    end
    bus.rresp_ready = 1'b1;
    @(negedge clk); bus.rresp_ready = 1'b0;
    checks++;
    if ({bus.rresp_valid, bus.pending_rd, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL rd_back_to_idle: got %b want 000", {bus.rresp_valid, bus.pending_rd, bus.busy});
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rd;
    exp_rd = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h60; bus.wr_data = 8'h11; bus.wr_slv = 7'h33;
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h70; bus.rd_slv = 7'h34;
    for (int t = 0; t < 4; t++) begin
      int n;
      n = 0;
      #1;
      while (!(bus.wr_ready || bus.rd_ready) && n < 10) begin
        @(negedge clk); #1; n++;
      end
      checks++;
      if ({bus.wr_ready, bus.rd_ready} !== {~exp_rd, exp_rd}) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: got %b want %b", t, {bus.wr_ready, bus.rd_ready}, {~exp_rd, exp_rd});
      end
      @(negedge clk);
      checks++;
      if ({bus.m_op_type, bus.m_addr} !== {exp_rd, (exp_rd ? 8'h70 : 8'h60)}) begin
        errors++;
        $display("FAIL b2b_cmd[%0d]: got %h want %h", t, {bus.m_op_type, bus.m_addr}, {exp_rd, (exp_rd ? 8'h70 : 8'h60)});
      end
      bus.m_cmd_ack = 1'b1;
      @(negedge clk); bus.m_cmd_ack = 1'b0;
      @(negedge clk);                                // WAIT with both requests still valid
      checks++;
      if ({bus.wr_ready, bus.rd_ready} !== 2'b00) begin
        errors++;
        $display("FAIL b2b_ready_busy[%0d]: got %b want 00", t, {bus.wr_ready, bus.rd_ready});
      end
      if (exp_rd) begin
        bus.m_rdata = 8'h40 + 8'(t); bus.m_rdata_valid = 1'b1;
      end else begin
        bus.m_wr_done = 1'b1;
      end
      @(negedge clk); bus.m_rdata_valid = 1'b0; bus.m_wr_done = 1'b0;
      checks++;
      if ({bus.bresp_valid, bus.rresp_valid, (exp_rd ? bus.rresp_data : 8'h00)}
          !== {~exp_rd, exp_rd, (exp_rd ? 8'h40 + 8'(t) : 8'h00)}) begin
        errors++;
        $display("FAIL b2b_resp[%0d]: got %h want %h", t, {bus.bresp_valid, bus.rresp_valid, (exp_rd ? bus.rresp_data : 8'h00)},
                 {~exp_rd, exp_rd, (exp_rd ? 8'h40 + 8'(t) : 8'h00)});
      end
      bus.bresp_ready = 1'b1; bus.rresp_ready = 1'b1;
      @(negedge clk); bus.bresp_ready = 1'b0; bus.rresp_ready = 1'b0;
      exp_rd = ~exp_rd;
    end
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout_write();
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h31; bus.wr_data = 8'h99; bus.wr_slv = 7'h12;
    @(negedge clk); bus.wr_valid = 1'b0; bus.m_cmd_ack = 1'b1;   // cycle 1
    for (int k = 1; k <= 17; k++) begin
      if (k == 2) bus.m_cmd_ack = 1'b0;
      checks++;
      if (bus.bresp_valid !== (k == 17)) begin
        errors++;
        $display("FAIL wr_timeout_cycle[%0d]: got %b want %b", k, bus.bresp_valid, (k == 17));
      end
      if (k < 17) @(negedge clk);
    end
    checks++;
    if ({bus.bresp_err, bus.pending_wr} !== 2'b11) begin
      errors++;
      $display("FAIL wr_timeout_err: got %b want 11", {bus.bresp_err, bus.pending_wr});
    end
    bus.bresp_ready = 1'b1;
    @(negedge clk); bus.bresp_ready = 1'b0;
  endtask

  task automatic test_timeout_read();
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h32; bus.rd_slv = 7'h13;
    @(negedge clk); bus.rd_valid = 1'b0;                         // cycle 1, never acked
    for (int k = 1; k <= 17; k++) begin
      checks++;
      if ({bus.rresp_valid, bus.m_cmd_valid} !== {(k == 17), (k < 17)}) begin
        errors++;
        $display("FAIL rd_timeout_cycle[%0d]: got %b want %b", k, {bus.rresp_valid, bus.m_cmd_valid}, {(k == 17), (k < 17)});
      end
      if (k < 17) @(negedge clk);
    end
    checks++;
    if ({bus.rresp_data, bus.rresp_err} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL rd_timeout_payload: got %h want 001", {bus.rresp_data, bus.rresp_err});
    end
    bus.rresp_ready = 1'b1;
    @(negedge clk); bus.rresp_ready = 1'b0;
  endtask

  task automatic test_nack();
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h05; bus.wr_data = 8'h06; bus.wr_slv = 7'h07;
    @(negedge clk); bus.wr_valid = 1'b0; bus.m_cmd_ack = 1'b1;
    @(negedge clk); bus.m_cmd_ack = 1'b0;
    @(negedge clk);
    bus.m_wr_done = 1'b1; bus.m_nack = 1'b1;
    @(negedge clk); bus.m_wr_done = 1'b0; bus.m_nack = 1'b0;
    checks++;
    if ({bus.bresp_valid, bus.bresp_err} !== 2'b11) begin
      errors++;
      $display("FAIL wr_nack: got %b want 11", {bus.bresp_valid, bus.bresp_err});
    end
    bus.bresp_ready = 1'b1;
    @(negedge clk); bus.bresp_ready = 1'b0;
  endtask

  task automatic test_done_timeout_tie(input logic is_rd, input logic nack_v, input logic [7:0] data);
    if (is_rd) begin
      bus.rd_valid = 1'b1; bus.rd_addr = 8'h44; bus.rd_slv = 7'h21;
    end else begin
      bus.wr_valid = 1'b1; bus.wr_addr = 8'h45; bus.wr_data = 8'h46; bus.wr_slv = 7'h22;
    end
    @(negedge clk); bus.wr_valid = 1'b0; bus.rd_valid = 1'b0; bus.m_cmd_ack = 1'b1;  // cycle 1
    @(negedge clk); bus.m_cmd_ack = 1'b0;                                             // cycle 2
    repeat (13) @(negedge clk);                                                       // cycle 15
    checks++;
    if ({bus.bresp_valid, bus.rresp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL tie_early_resp[rd=%0b]: got %b want 00", is_rd, {bus.bresp_valid, bus.rresp_valid});
    end
    @(negedge clk);                                                                   // cycle 16
    bus.m_nack = nack_v;
    if (is_rd) begin
      bus.m_rdata = data; bus.m_rdata_valid = 1'b1;
    end else begin
      bus.m_wr_done = 1'b1;
    end
    @(negedge clk); bus.m_wr_done = 1'b0; bus.m_rdata_valid = 1'b0; bus.m_nack = 1'b0;
    checks++;
    if (is_rd) begin
      if ({bus.rresp_valid, bus.rresp_data, bus.rresp_err} !== {1'b1, data, nack_v}) begin
        errors++;
        $display("FAIL tie_rd[nack=%0b]: got %h want %h", nack_v, {bus.rresp_valid, bus.rresp_data, bus.rresp_err}, {1'b1, data, nack_v});
      end
    end else begin
      if ({bus.bresp_valid, bus.bresp_err} !== {1'b1, nack_v}) begin
        errors++;
        $display("FAIL tie_wr[nack=%0b]: got %b want %b", nack_v, {bus.bresp_valid, bus.bresp_err}, {1'b1, nack_v});
      end
    end
    bus.bresp_ready = 1'b1; bus.rresp_ready = 1'b1;
    @(negedge clk); bus.bresp_ready = 1'b0; bus.rresp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Reset during WAIT of a write, with both requests waiting on the inputs
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h77; bus.wr_data = 8'h88; bus.wr_slv = 7'h55;
    @(negedge clk); bus.wr_valid = 1'b0; bus.m_cmd_ack = 1'b1;
    @(negedge clk); bus.m_cmd_ack = 1'b0;
    @(negedge clk);                                  // WAIT
    reset = 1'b1;
    bus.wr_valid = 1'b1; bus.rd_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_vec() !== 44'h0) begin
      errors++;
      $display("FAIL reset_in_wait: got %h want 0", outs_vec());
    end
    reset = 1'b0; #1;
    checks++;
    if ({bus.wr_ready, bus.rd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_grant_write_first: got %b want 10", {bus.wr_ready, bus.rd_ready});
    end
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0; bus.m_wr_done = 1'b1;
    @(negedge clk); bus.m_wr_done = 1'b0;
    checks++;
    if ({bus.bresp_valid, bus.busy, bus.m_trigger} !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_stale_resp: got %b want 000", {bus.bresp_valid, bus.busy, bus.m_trigger});
    end
    // Reset while a read response is stalled
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h66; bus.rd_slv = 7'h56;
    @(negedge clk); bus.rd_valid = 1'b0; bus.m_cmd_ack = 1'b1;
    @(negedge clk); bus.m_cmd_ack = 1'b0;
    @(negedge clk);
    bus.m_rdata = 8'h77; bus.m_rdata_valid = 1'b1;
    @(negedge clk); bus.m_rdata_valid = 1'b0;
    checks++;
    if ({bus.rresp_valid, bus.rresp_data} !== {1'b1, 8'h77}) begin
      errors++;
      $display("FAIL resp_before_reset: got %h want 177", {bus.rresp_valid, bus.rresp_data});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_vec() !== 44'h0) begin
      errors++;
      $display("FAIL reset_in_resp: got %h want 0", outs_vec());
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_vec() !== 44'h0) begin
      errors++;
      $display("FAIL reset_resp_cleared: got %h want 0", outs_vec());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_addr = 8'h00; bus.wr_data = 8'h00; bus.wr_slv = 7'h00;
    bus.rd_valid = 1'b0; bus.rd_addr = 8'h00; bus.rd_slv = 7'h00;
    bus.bresp_ready = 1'b0; bus.rresp_ready = 1'b0;
    bus.m_cmd_ack = 1'b0; bus.m_wr_done = 1'b0; bus.m_nack = 1'b0;
    bus.m_rdata = 8'h00; bus.m_rdata_valid = 1'b0;

    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_timeout_write();
    test_timeout_read();
    test_nack();
    test_done_timeout_tie(1'b0, 1'b0, 8'h00);
    test_done_timeout_tie(1'b0, 1'b1, 8'h00);
    test_done_timeout_tie(1'b1, 1'b0, 8'h5A);
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
